fp_add_normalize: RTL and testbench
===================================

Name: fp_add_normalize

Overview:
- Pipeline stage directly downstream of mantissa alignment in the dual-mode FP adder.
- Consumes the aligned large and small fractions plus the large exponent, and performs the effective add/subtract per lane.
- Normalizes the result with a leading-zero count and adjusts the exponent, then hands an unrounded result to the rounding stage.
- Modes: i_mode=1 is one double lane (53-bit significand, 11-bit exponent). i_mode=0 is two single lanes (24-bit significands, 8-bit exponents).

Parameters:
- EXP_MAX_D, 2047, all-ones double exponent (overflow/Inf encoding).
- EXP_MAX_S, 255, all-ones single exponent.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_valid  in  1  input beat valid.
- i_ready  out  1  stage can accept a beat.
- i_mode  in  1  1=double, 0=dual single.
- a_eff_sub  in  2  per-lane effective subtract; bit0 = lane0/double, bit1 = lane1.
- a_sign  in  2  per-lane sign of the large operand.
- a_large_exp  in  16  mode1: exp in [10:0]; mode0: lane0 in [7:0], lane1 in [15:8].
- a_aligned_large_frac54  in  54  mode1: [52:0]; mode0: lane0 [23:0], lane1 [52:29].
- a_aligned_small_frac54  in  54  same layout; [53] and mode0 [28:24] are zero.
- a_sticky  in  2  per-lane OR of bits shifted out during alignment.
- n_valid  out  1  output beat valid.
- o_ready  in  1  downstream accepts.
- n_frac53  out  53  normalized significand, same lane layout; mode0 [28:24] = 0.
- n_exp  out  16  adjusted exponent, same layout as a_large_exp.
- n_sign  out  2  per-lane result sign.
- n_sticky  out  2  per-lane sticky after normalization.
- n_zero, n_ovf, n_unf  out  2 each  per-lane exact-zero, overflow, subnormal/underflow flags.

Clock/reset: one clock i_clk; reset i_rst_n, asynchronous, active-low.

Behaviour:
- Reset: both pipeline valids = 0; n_valid and every data/flag output = 0; i_ready = 1 from the first cycle after reset deasserts.
- Pipeline: 2 register stages, S1 (add/sub) and S2 (normalize). Latency is 2 cycles from input acceptance to n_valid. Throughput is 1 beat/cycle.
- Handshake:
  - A beat transfers when valid & ready are both high.
  - S2 advances when !n_valid | o_ready; S1 advances when !s1_valid | S2 advances; i_ready = S1 advances.
  - Outputs hold stable while n_valid & !o_ready. No beat is dropped or duplicated.
- S1 arithmetic:
  - Mode1: 54-bit add/sub of [52:0].
  - Mode0: independent 25-bit add/sub per lane; no carry crosses bits [28:24].
  - Subtract with small > large (equal-exponent case): take the two's-complement magnitude and invert that lane's sign.
  - a_sticky is ORed into the subtract borrow, i.e. subtract one LSB when sticky=1 and eff_sub=1.
- S2 normalize, per lane:
  - Carry-out: shift right 1, exp+1; shifted-out bit ORs into sticky.
  - Otherwise: lz = leading-zero count relative to the hidden-bit position. If exp > lz: shift left lz, exp - lz. Else: shift left exp-1, exp = 0, n_unf = 1.
  - Zero magnitude with sticky=0: frac = 0, exp = 0, n_zero = 1, sign = 0 (+0).
  - exp+1 reaching EXP_MAX: n_ovf = 1, exp = EXP_MAX, frac = 0 (Inf).
  - Input exp = 0 (subnormal operands): no left shift; a carry into the hidden bit sets exp = 1.
- Lanes are fully independent in mode0; lane1 flags are 0 in mode1.
- Reset mid-operation discards all in-flight beats.

Decomposition:
- Shared package fp_pkg holds:
  - EXP_MAX_D, EXP_MAX_S;
  - lane bit positions (LANE0_LSB=0, LANE0_MSB=23, LANE1_LSB=29, LANE1_MSB=52, DBL_MSB=52);
  - exponent field widths (11, 8).
- One sub-module, fp_lzc: parameterized-width leading-zero counter, instantiated once for 54 bits and twice for 25 bits.

Test Plan:
- Double 1.0+1.0: mode1, large = small = 53'h10000000000000, exp 0x3FF, eff_sub=0 -> n_frac 53'h10000000000000, n_exp 0x400, flags 0, n_valid 2 cycles after accept.
- Double 1.0-1.0: eff_sub=1 -> n_zero[0]=1, n_exp 0, n_frac 0, n_sign[0]=0.
- Single lane0 1.5-1.0 and lane1 overflow in one beat:
  - Lane0: large 24'hC00000, small 24'h800000, exp 0x7F, sub -> lane0 frac 24'h800000, exp 0x7E.
  - Lane1: 1.0+1.0 at exp 0xFE -> n_ovf[1]=1, lane1 exp 0xFF, frac 0.
  - Bits [28:24] stay 0.
- Sign flip: mode1, sub, large 53'h10000000000000, small 53'h18000000000000, sign 0 -> frac 53'h10000000000000, exp-1, n_sign[0]=1.
- Backpressure: 4 back-to-back beats, o_ready low 3 cycles mid-stream -> i_ready drops once both stages are full, outputs held stable, all 4 delivered in order.
- Reset mid-stream: drop i_rst_n with 2 beats in flight -> n_valid=0 and outputs 0 asynchronously, nothing emitted after release.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared constants, lane layout and datapath helpers for the dual-mode FP adder.
package fp_pkg;

    localparam int unsigned EXP_MAX_D = 2047;
    localparam int unsigned EXP_MAX_S = 255;

    localparam int unsigned LANE0_LSB = 0;
    localparam int unsigned LANE0_MSB = 23;
    localparam int unsigned LANE1_LSB = 29;
    localparam int unsigned LANE1_MSB = 52;
    localparam int unsigned DBL_MSB   = 52;

    localparam int unsigned EXP_W_D = 11;
    localparam int unsigned EXP_W_S = 8;

    typedef struct packed {
        logic [52:0] frac;
        logic [10:0] exp;
        logic        sticky;
        logic        zero;
        logic        ovf;
        logic        unf;
    } norm_t;

    // Returns {sign_flip, magnitude}; sticky acts as an extra borrow on subtract.
    function automatic logic [54:0] fp_addsub(input logic [53:0] l, input logic [53:0] s,
                                              input logic sub, input logic sticky);
        logic [54:0] d;
        if (!sub) begin
            return {1'b0, l + s};
        end
        d = {1'b0, l} - {1'b0, s} - {54'd0, sticky};
        if (d[54]) begin
            return {1'b1, ~d[53:0] + 54'd1};
        end
        return {1'b0, d[53:0]};
    endfunction

    // cpos is the carry-out bit position; the hidden bit sits just below it.
    function automatic norm_t fp_normalize(input logic [53:0] mag, input logic [5:0] cpos,
                                           input logic [10:0] exp, input logic sticky,
                                           input logic [10:0] exp_max, input logic [5:0] lzc);
        norm_t      r;
        logic [5:0] lz;
        r        = '0;
        r.sticky = sticky;
        r.exp    = exp;
        lz       = lzc - 6'd1;
        if (mag[cpos]) begin
            r.frac   = mag[53:1];
            r.exp    = exp + 11'd1;
            r.sticky = sticky | mag[0];
            if (r.exp == exp_max) begin
                r.ovf  = 1'b1;
                r.frac = '0;
            end
        end else if (mag == '0 && !sticky) begin
            r.exp  = '0;
            r.zero = 1'b1;
        end else if (exp == '0) begin
            r.frac = mag[52:0];
            r.exp  = {10'd0, mag[cpos-6'd1]};
            r.unf  = ~mag[cpos-6'd1];
        end else if (exp > {5'd0, lz}) begin
            r.frac = mag[52:0] << lz;
            r.exp  = exp - {5'd0, lz};
        end else begin
            r.frac = mag[52:0] << (exp - 11'd1);
            r.exp  = '0;
            r.unf  = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/fp_lzc.sv
// Leading-zero counter; an all-zero input reports WIDTH.
module fp_lzc #(
    parameter int unsigned WIDTH = 54,
    localparam int unsigned CW = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] i_data,
    output logic [CW-1:0]    o_count
);

    always_comb begin
        o_count = CW'(WIDTH);
        // Ascending scan so the highest set bit wins.
        for (int i = 0; i < WIDTH; i++) begin
            if (i_data[i]) begin
                o_count = CW'(WIDTH - 1 - i);
            end
        end
    end

endmodule

// File: rtl/fp_add_normalize.sv
// Two-stage add/sub + normalize stage of the dual-mode FP adder.
// S1 forms the lane magnitudes, S2 normalizes them and flags zero/overflow/underflow.
module fp_add_normalize
    import fp_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_valid,
    output logic        i_ready,
    input  logic        i_mode,
    input  logic [1:0]  a_eff_sub,
    input  logic [1:0]  a_sign,
    input  logic [15:0] a_large_exp,
    input  logic [53:0] a_aligned_large_frac54,
    input  logic [53:0] a_aligned_small_frac54,
    input  logic [1:0]  a_sticky,
    output logic        n_valid,
    input  logic        o_ready,
    output logic [52:0] n_frac53,
    output logic [15:0] n_exp,
    output logic [1:0]  n_sign,
    output logic [1:0]  n_sticky,
    output logic [1:0]  n_zero,
    output logic [1:0]  n_ovf,
    output logic [1:0]  n_unf
);

    logic        r_s1_valid, r_s1_mode;
    logic [53:0] r_s1_mag;
    logic [15:0] r_s1_exp;
    logic [1:0]  r_s1_sign, r_s1_sticky;

    logic        r_n_valid;
    logic [52:0] r_n_frac;
    logic [15:0] r_n_exp;
    logic [1:0]  r_n_sign, r_n_sticky, r_n_zero, r_n_ovf, r_n_unf;

    logic        w_s1_adv, w_s2_adv;
    logic [54:0] w_as_d, w_as_0, w_as_1;
    logic [53:0] w_s1_mag;
    logic [15:0] w_s1_exp;
    logic [1:0]  w_s1_sign, w_s1_sticky;

    logic [5:0]  w_lzc_d;
    logic [4:0]  w_lzc_0, w_lzc_1;
    norm_t       w_nd, w_n0, w_n1;
    logic [52:0] w_n_frac;
    logic [15:0] w_n_exp;
    logic [1:0]  w_n_sign, w_n_sticky, w_n_zero, w_n_ovf, w_n_unf;
    logic        w_unused;

    assign w_s2_adv = !r_n_valid || o_ready;
    assign w_s1_adv = !r_s1_valid || w_s2_adv;
    assign i_ready  = w_s1_adv;

    always_comb begin
        w_as_d = fp_addsub({1'b0, a_aligned_large_frac54[DBL_MSB:0]},
                           {1'b0, a_aligned_small_frac54[DBL_MSB:0]}, a_eff_sub[0], a_sticky[0]);
        w_as_0 = fp_addsub({30'd0, a_aligned_large_frac54[LANE0_MSB:LANE0_LSB]},
                           {30'd0, a_aligned_small_frac54[LANE0_MSB:LANE0_LSB]},
                           a_eff_sub[0], a_sticky[0]);
        w_as_1 = fp_addsub({30'd0, a_aligned_large_frac54[LANE1_MSB:LANE1_LSB]},
                           {30'd0, a_aligned_small_frac54[LANE1_MSB:LANE1_LSB]},
                           a_eff_sub[1], a_sticky[1]);
        if (i_mode) begin
            w_s1_mag    = w_as_d[53:0];
            w_s1_sign   = {1'b0, a_sign[0] ^ w_as_d[54]};
            w_s1_exp    = {5'd0, a_large_exp[EXP_W_D-1:0]};
            w_s1_sticky = {1'b0, a_sticky[0]};
        end else begin
            // Lane1 carry lands on bit 53, lane0 carry on bit 24; [28:25] stay clear.
            w_s1_mag    = {w_as_1[24:0], 4'd0, w_as_0[24:0]};
            w_s1_sign   = {a_sign[1] ^ w_as_1[54], a_sign[0] ^ w_as_0[54]};
            w_s1_exp    = a_large_exp;
            w_s1_sticky = a_sticky;
        end
    end

    fp_lzc #(.WIDTH(54)) u_lzc_d (.i_data(r_s1_mag),        .o_count(w_lzc_d));
    fp_lzc #(.WIDTH(25)) u_lzc_0 (.i_data(r_s1_mag[24:0]),  .o_count(w_lzc_0));
    fp_lzc #(.WIDTH(25)) u_lzc_1 (.i_data(r_s1_mag[53:29]), .o_count(w_lzc_1));

    always_comb begin
        w_nd = fp_normalize(r_s1_mag, 6'd53, r_s1_exp[EXP_W_D-1:0], r_s1_sticky[0],
                            11'(EXP_MAX_D), w_lzc_d);
        w_n0 = fp_normalize({29'd0, r_s1_mag[24:0]}, 6'd24, {3'd0, r_s1_exp[EXP_W_S-1:0]},
                            r_s1_sticky[0], 11'(EXP_MAX_S), {1'b0, w_lzc_0});
        w_n1 = fp_normalize({29'd0, r_s1_mag[53:29]}, 6'd24, {3'd0, r_s1_exp[15:EXP_W_S]},
                            r_s1_sticky[1], 11'(EXP_MAX_S), {1'b0, w_lzc_1});
        if (r_s1_mode) begin
            w_n_frac   = w_nd.frac;
            w_n_exp    = {5'd0, w_nd.exp};
            w_n_sign   = {1'b0, r_s1_sign[0] & ~w_nd.zero};
            w_n_sticky = {1'b0, w_nd.sticky};
            w_n_zero   = {1'b0, w_nd.zero};
            w_n_ovf    = {1'b0, w_nd.ovf};
            w_n_unf    = {1'b0, w_nd.unf};
        end else begin
            w_n_frac   = {w_n1.frac[23:0], 5'd0, w_n0.frac[23:0]};
            w_n_exp    = {w_n1.exp[7:0], w_n0.exp[7:0]};
            w_n_sign   = {r_s1_sign[1] & ~w_n1.zero, r_s1_sign[0] & ~w_n0.zero};
            w_n_sticky = {w_n1.sticky, w_n0.sticky};
            w_n_zero   = {w_n1.zero, w_n0.zero};
            w_n_ovf    = {w_n1.ovf, w_n0.ovf};
            w_n_unf    = {w_n1.unf, w_n0.unf};
        end
    end

    assign w_unused = ^{w_as_0[53:25], w_as_1[53:25], a_aligned_large_frac54[53],
                        a_aligned_small_frac54[53], w_n0.frac[52:24], w_n1.frac[52:24],
                        w_n0.exp[10:8], w_n1.exp[10:8]};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s1_valid  <= 1'b0;
            r_s1_mode   <= 1'b0;
            r_s1_mag    <= '0;
            r_s1_exp    <= '0;
            r_s1_sign   <= '0;
            r_s1_sticky <= '0;
            r_n_valid   <= 1'b0;
            r_n_frac    <= '0;
            r_n_exp     <= '0;
            r_n_sign    <= '0;
            r_n_sticky  <= '0;
            r_n_zero    <= '0;
            r_n_ovf     <= '0;
            r_n_unf     <= '0;
        end else begin
            if (w_s1_adv) begin
                r_s1_valid <= i_valid;
            end
            if (w_s1_adv && i_valid) begin
                r_s1_mode   <= i_mode;
                r_s1_mag    <= w_s1_mag;
                r_s1_exp    <= w_s1_exp;
                r_s1_sign   <= w_s1_sign;
                r_s1_sticky <= w_s1_sticky;
            end
            if (w_s2_adv) begin
                r_n_valid <= r_s1_valid;
            end
            if (w_s2_adv && r_s1_valid) begin
                r_n_frac   <= w_n_frac;
                r_n_exp    <= w_n_exp;
                r_n_sign   <= w_n_sign;
                r_n_sticky <= w_n_sticky;
                r_n_zero   <= w_n_zero;
                r_n_ovf    <= w_n_ovf;
                r_n_unf    <= w_n_unf;
            end
        end
    end

    assign n_valid  = r_n_valid;
    assign n_frac53 = r_n_frac;
    assign n_exp    = r_n_exp;
    assign n_sign   = r_n_sign;
    assign n_sticky = r_n_sticky;
    assign n_zero   = r_n_zero;
    assign n_ovf    = r_n_ovf;
    assign n_unf    = r_n_unf;

endmodule

// File: tb/tb_fp_add_normalize.sv
// Directed-vector bench for fp_add_normalize with hand-computed expectations.
module tb_fp_add_normalize;

    logic        i_clk, i_rst_n, i_valid, i_ready, i_mode, n_valid, o_ready;
    logic [1:0]  a_eff_sub, a_sign, a_sticky;
    logic [15:0] a_large_exp, n_exp;
    logic [53:0] a_aligned_large_frac54, a_aligned_small_frac54;
    logic [52:0] n_frac53;
    logic [1:0]  n_sign, n_sticky, n_zero, n_ovf, n_unf;

    int errors;
    int checks;

    localparam logic [53:0] ONE_D = {1'b0, 53'h10000000000000};

    fp_add_normalize u_dut (
        .i_clk                 (i_clk),
        .i_rst_n               (i_rst_n),
        .i_valid               (i_valid),
        .i_ready               (i_ready),
        .i_mode                (i_mode),
        .a_eff_sub             (a_eff_sub),
        .a_sign                (a_sign),
        .a_large_exp           (a_large_exp),
        .a_aligned_large_frac54(a_aligned_large_frac54),
        .a_aligned_small_frac54(a_aligned_small_frac54),
        .a_sticky              (a_sticky),
        .n_valid               (n_valid),
        .o_ready               (o_ready),
        .n_frac53              (n_frac53),
        .n_exp                 (n_exp),
        .n_sign                (n_sign),
        .n_sticky              (n_sticky),
        .n_zero                (n_zero),
        .n_ovf                 (n_ovf),
        .n_unf                 (n_unf)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic mode, input logic [1:0] sub, input logic [1:0] sgn,
                         input logic [1:0] stk, input logic [15:0] exp,
                         input logic [53:0] lg, input logic [53:0] sm);
        i_valid                = 1'b1;
        i_mode                 = mode;
        a_eff_sub              = sub;
        a_sign                 = sgn;
        a_sticky               = stk;
        a_large_exp            = exp;
        a_aligned_large_frac54 = lg;
        a_aligned_small_frac54 = sm;
    endtask

    // Called at a negedge with a beat driven into an empty pipeline.
    task automatic run_beat(input string tag);
        #1;
        check_eq({tag, " i_ready"}, 64'(i_ready), 64'd1);
        @(posedge i_clk);
        #1 i_valid = 1'b0;
        @(negedge i_clk);
        check_eq({tag, " lat1"}, 64'(n_valid), 64'd0);
        @(negedge i_clk);
        check_eq({tag, " n_valid"}, 64'(n_valid), 64'd1);
    endtask

    task automatic check_out(input string tag, input logic [52:0] frac, input logic [15:0] exp,
                             input logic [1:0] sgn, input logic [1:0] stk, input logic [1:0] zero,
                             input logic [1:0] ovf, input logic [1:0] unf);
        check_eq({tag, " frac"}, 64'(n_frac53), 64'(frac));
        check_eq({tag, " exp"}, 64'(n_exp), 64'(exp));
        check_eq({tag, " sign"}, 64'(n_sign), 64'(sgn));
        check_eq({tag, " sticky"}, 64'(n_sticky), 64'(stk));
        check_eq({tag, " flags"}, 64'({n_zero, n_ovf, n_unf}), 64'({zero, ovf, unf}));
    endtask

    initial begin
        logic [52:0] got_frac[$];
        logic [15:0] got_exp[$];
        logic [52:0] held_frac;
        logic [15:0] held_exp;
        bit          stalled_prev;
        bit          saw_stall;
        int          sent;
        int          late_valid;

        errors   = 0;
        checks   = 0;
        i_rst_n  = 1'b0;
        o_ready  = 1'b1;
        i_valid  = 1'b0;
        drive(1'b0, 2'b00, 2'b00, 2'b00, 16'h0, 54'h0, 54'h0);
        i_valid  = 1'b0;
        repeat (2) @(negedge i_clk);
        check_eq("rst n_valid", 64'(n_valid), 64'd0);
        check_out("rst", 53'h0, 16'h0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
        i_rst_n = 1'b1;
        #1 check_eq("rst i_ready", 64'(i_ready), 64'd1);
        @(negedge i_clk);

        drive(1'b1, 2'b00, 2'b00, 2'b00, 16'h03FF, ONE_D, ONE_D);
        run_beat("dadd");
        check_out("dadd", 53'h10000000000000, 16'h0400, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);

        drive(1'b1, 2'b01, 2'b00, 2'b00, 16'h03FF, ONE_D, ONE_D);
        run_beat("dzero");
        check_out("dzero", 53'h0, 16'h0, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00);

        drive(1'b0, 2'b01, 2'b00, 2'b00, {8'hFE, 8'h7F},
              {1'b0, 24'h800000, 5'd0, 24'hC00000}, {1'b0, 24'h800000, 5'd0, 24'h800000});
        run_beat("single");
        check_out("single", 53'h800000, 16'hFF7E, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00);
        check_eq("single gap", 64'(n_frac53[28:24]), 64'd0);

        drive(1'b1, 2'b01, 2'b00, 2'b00, 16'h03FF, ONE_D, {1'b0, 53'h18000000000000});
        run_beat("flip");
        check_out("flip", 53'h10000000000000, 16'h03FE, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00);

        drive(1'b1, 2'b01, 2'b00, 2'b01, 16'h03FF, ONE_D, 54'h0);
        run_beat("borrow");
        check_out("borrow", 53'h1FFFFFFFFFFFFE, 16'h03FE, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00);

        drive(1'b1, 2'b01, 2'b00, 2'b00, 16'h0001, {1'b0, 53'h18000000000000}, ONE_D);
        run_beat("unf");
        check_out("unf", 53'h08000000000000, 16'h0000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01);

        drive(1'b0, 2'b00, 2'b10, 2'b00, {8'h80, 8'h00},
              {1'b0, 24'h800000, 5'd0, 24'h400000}, {1'b0, 24'h000000, 5'd0, 24'h400000});
        run_beat("subn");
        check_out("subn", {24'h800000, 5'd0, 24'h800000}, 16'h8001, 2'b10, 2'b00, 2'b00,
                  2'b00, 2'b00);

        // Backpressure: four beats, consumer stalls for three cycles.
        repeat (2) @(negedge i_clk);
        sent         = 0;
        stalled_prev = 1'b0;
        saw_stall    = 1'b0;
        for (int cyc = 0; cyc < 30 && got_frac.size() < 4; cyc++) begin
            o_ready = !(cyc >= 2 && cyc <= 4);
            if (sent < 4) begin
                drive(1'b1, 2'b00, 2'b00, 2'b00, 16'h0100 + 16'(sent), ONE_D, 54'(sent + 1));
            end else begin
                i_valid = 1'b0;
            end
            #1;
            if (stalled_prev) begin
                check_eq("bp hold frac", 64'(n_frac53), 64'(held_frac));
                check_eq("bp hold exp", 64'(n_exp), 64'(held_exp));
            end
            stalled_prev = n_valid && !o_ready;
            held_frac    = n_frac53;
            held_exp     = n_exp;
            if (i_valid && !i_ready) saw_stall = 1'b1;
            if (n_valid && o_ready) begin
                got_frac.push_back(n_frac53);
                got_exp.push_back(n_exp);
            end
            if (i_valid && i_ready) sent++;
            @(negedge i_clk);
        end
        i_valid = 1'b0;
        o_ready = 1'b1;
        check_eq("bp count", 64'(got_frac.size()), 64'd4);
        check_eq("bp stall", 64'(saw_stall), 64'd1);
        for (int k = 0; k < got_frac.size(); k++) begin
            check_eq("bp order frac", 64'(got_frac[k]), 64'(53'h10000000000000 + 53'(k + 1)));
            check_eq("bp order exp", 64'(got_exp[k]), 64'(16'h0100 + 16'(k)));
        end

        // Reset with two beats in flight.
        repeat (2) @(negedge i_clk);
        o_ready = 1'b0;
        drive(1'b1, 2'b00, 2'b00, 2'b00, 16'h03FF, ONE_D, ONE_D);
        @(negedge i_clk);
        drive(1'b1, 2'b00, 2'b00, 2'b00, 16'h0200, ONE_D, ONE_D);
        @(negedge i_clk);
        i_valid = 1'b0;
        check_eq("rst2 pre n_valid", 64'(n_valid), 64'd1);
        #2 i_rst_n = 1'b0;
        #1;
        check_eq("rst2 n_valid", 64'(n_valid), 64'd0);
        check_out("rst2", 53'h0, 16'h0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
        @(negedge i_clk);
        i_rst_n    = 1'b1;
        o_ready    = 1'b1;
        late_valid = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge i_clk);
            if (n_valid) late_valid++;
        end
        check_eq("rst2 nothing out", 64'(late_valid), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
